// File: rtl/checksum_sequencer.sv
// Internet checksum sequencer: pseudo-header plus payload, one's-complement sum.
// Optional macro CKSUM_ZERO_SUB_EN turns a computed 16'h0000 into 16'hFFFF.
`timescale 1ns/1ps

module checksum_sequencer #(
   parameter int CNT_W = 14
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        start,
   input  logic [31:0] src_ip,
   input  logic [31:0] dst_ip,
   input  logic [7:0]  protocol,
   input  logic [15:0] seg_len,
   input  logic [31:0] s_data,
   input  logic [3:0]  s_keep,
   input  logic        s_valid,
   input  logic        s_last,
   output logic        s_ready,
   output logic        busy,
   output logic [15:0] cksum,
   output logic        cksum_valid,
   input  logic        cksum_ready,
   output logic        len_err
);

   typedef enum logic [2:0] {
      IDLE,
      PH0,
      PH1,
      PH2,
      PAYLOAD,
      FOLD1,
      FOLD2,
      DONE
   } state_t;

   state_t state_q;
   state_t state_d;

   logic [31:0]      src_q;
   logic [31:0]      dst_q;
   logic [7:0]       proto_q;
   logic [15:0]      len_q;
   logic [31:0]      acc_q;
   logic [CNT_W-1:0] cnt_q;
   logic             ovf_q;
   logic [16:0]      fold17_q;
   logic [15:0]      fold16_q;

   logic        beat_fire;
   logic [31:0] beat_word;
   logic [31:0] ph2_word;
   logic [16:0] exp_words;
   logic [16:0] cnt_ext;
   logic [15:0] ck_inv;
   logic [15:0] ck_final;

   // 32-bit one's-complement add; the end-around carry cannot carry again.
   function automatic logic [31:0] add1c(
      input logic [31:0] a,
      input logic [31:0] b
   );
      logic [32:0] s;
      s = {1'b0, a} + {1'b0, b};
      return s[31:0] + {31'd0, s[32]};
   endfunction

   assign beat_fire = s_valid && (state_q == PAYLOAD);

   assign beat_word = s_data & {{8{s_keep[3]}}, {8{s_keep[2]}},
                                {8{s_keep[1]}}, {8{s_keep[0]}}};

   assign ph2_word  = {8'h00, proto_q, len_q};

   assign exp_words = ({1'b0, len_q} + 17'd3) >> 2;
   assign cnt_ext   = 17'(cnt_q);

   assign ck_inv = ~fold16_q;
`ifdef CKSUM_ZERO_SUB_EN
   assign ck_final = (ck_inv == 16'h0000) ? 16'hFFFF : ck_inv;
`else
   assign ck_final = ck_inv;
`endif

   // State register.
   always_ff @(posedge clk) begin
      if (reset) state_q <= IDLE;
      else       state_q <= state_d;
   end

   // Next-state decode.
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         IDLE:    if (start) state_d = PH0;
         PH0:     state_d = PH1;
         PH1:     state_d = PH2;
         PH2:     state_d = (len_q != 16'd0) ? PAYLOAD : FOLD1;
         PAYLOAD: if (beat_fire && s_last) state_d = FOLD1;
         FOLD1:   state_d = FOLD2;
         FOLD2:   state_d = DONE;
         DONE:    if (cksum_ready) state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // Field capture, accumulation, word counting and folding.
   always_ff @(posedge clk) begin
      if (reset) begin
         src_q    <= '0;
         dst_q    <= '0;
         proto_q  <= '0;
         len_q    <= '0;
         acc_q    <= '0;
         cnt_q    <= '0;
         ovf_q    <= 1'b0;
         fold17_q <= '0;
         fold16_q <= '0;
      end else begin
         unique case (state_q)
            IDLE: begin
               if (start) begin
                  src_q   <= src_ip;
                  dst_q   <= dst_ip;
                  proto_q <= protocol;
                  len_q   <= seg_len;
                  acc_q   <= '0;
                  cnt_q   <= '0;
                  ovf_q   <= 1'b0;
               end
            end
            PH0: acc_q <= add1c(acc_q, src_q);
            PH1: acc_q <= add1c(acc_q, dst_q);
            PH2: acc_q <= add1c(acc_q, ph2_word);
            PAYLOAD: begin
               if (beat_fire) begin
                  acc_q <= add1c(acc_q, beat_word);
                  if (&cnt_q) ovf_q <= 1'b1;
                  else        cnt_q <= cnt_q + 1'b1;
               end
            end
            FOLD1: fold17_q <= {1'b0, acc_q[31:16]} + {1'b0, acc_q[15:0]};
            FOLD2: fold16_q <= fold17_q[15:0] + {15'd0, fold17_q[16]};
            default: ;
         endcase
      end
   end

   // Outputs follow the state; everything is held quiet while reset is high.
   always_comb begin
      s_ready     = 1'b0;
      busy        = 1'b0;
      cksum       = 16'h0000;
      cksum_valid = 1'b0;
      len_err     = 1'b0;
      if (!reset) begin
         busy    = (state_q != IDLE);
         s_ready = (state_q == PAYLOAD);
         if (state_q == DONE) begin
            cksum_valid = 1'b1;
            cksum       = ck_final;
            len_err     = ovf_q || (cnt_ext != exp_words);
         end
      end
   end

endmodule
